i2cmb_xfer_sequencer: RTL

I2CMB_XFER_SEQUENCER -- requirements
Module: i2cmb_xfer_sequencer

---
 rtl/i2cmb_ctrl_pkg.sv | 56 +++++
 rtl/i2cmb_wb_access.sv | 49 ++++
 rtl/i2cmb_xfer_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2cmb_ctrl_pkg.sv
// Shared IICMB register map, command codes, status bit positions and the
// sequencer's state encodings.
package i2cmb_ctrl_pkg;

  localparam logic [1:0] REG_CSR  = 2'd0;
  localparam logic [1:0] REG_DPR  = 2'd1;
  localparam logic [1:0] REG_CMDR = 2'd2;

  localparam logic [7:0] CSR_ENABLE = 8'hC0;

  typedef enum logic [2:0] {
    CMD_WRITE    = 3'b001,
    CMD_READ_ACK = 3'b010,
    CMD_READ_NAK = 3'b011,
    CMD_START    = 3'b100,
    CMD_STOP     = 3'b101,
    CMD_SET_BUS  = 3'b110
  } cmd_t;

  localparam int unsigned STAT_DON = 7;
  localparam int unsigned STAT_NAK = 6;
  localparam int unsigned STAT_AL  = 5;
  localparam int unsigned STAT_ERR = 4;

  typedef enum logic [2:0] {
    ST_RESET_INIT,
    ST_IDLE,
    ST_START,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_STOP,
    ST_FINISH
  } state_t;

  // Sub-steps shared by every bus-facing state.
  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_WB,
    PH_IRQ,
    PH_BYTE
  } phase_t;

  // What the in-flight Wishbone access was for, so its completion is routed correctly.
  typedef enum logic [1:0] {
    K_SETUP,
    K_CMD,
    K_STAT,
    K_RDDPR
  } kind_t;

  function automatic logic [7:0] cmdr_word(input cmd_t c);
    return {5'b00000, c};
  endfunction

endpackage

// File: rtl/i2cmb_wb_access.sv
// Single Wishbone master access: launch on start, hold until ack, then drop
// cyc/stb and pulse done with the captured read data.
module i2cmb_wb_access (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       we,
  input  logic [1:0] adr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done  <= 1'b0;
      rdata <= '0;
      cyc_o <= 1'b0;
      stb_o <= 1'b0;
      we_o  <= 1'b0;
      adr_o <= '0;
      dat_o <= '0;
    end else begin
      done <= 1'b0;
      if (cyc_o) begin
        if (ack_i) begin
          cyc_o <= 1'b0;
          stb_o <= 1'b0;
          done  <= 1'b1;
          if (!we_o) rdata <= dat_i;
        end
      end else if (start) begin
        cyc_o <= 1'b1;
        stb_o <= 1'b1;
        we_o  <= we;
        adr_o <= adr;
        dat_o <= wdata;
      end
    end
  end

endmodule

// File: rtl/i2cmb_xfer_sequencer.sv
// Drives one I2C transfer at a time through an IICMB core: init, START,
// address, data bytes, STOP, with irq-paced command completion.
module i2cmb_xfer_sequencer
  import i2cmb_ctrl_pkg::*;
#(
  parameter int unsigned BUS_ID       = 0,
  parameter int unsigned WAIT_TIMEOUT = 1000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [6:0] req_addr_i,
  input  logic       req_op_i,
  input  logic [5:0] req_len_i,
  input  logic [7:0] wr_data_i,
  input  logic       wr_valid_i,
  output logic       wr_ready_o,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  output logic       done_o,
  output logic       nak_o,
  output logic       err_o,
  output logic       busy_o,
  output logic       cyc_o,
  output logic       stb_o,
  output logic       we_o,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  input  logic       ack_i,
  input  logic       irq_i
);

  localparam int unsigned WCW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_TIMEOUT - 1);

  state_t         state;
  phase_t         phase;
  kind_t          kind;
  logic [1:0]     step;
  logic [6:0]     addr_q;
  logic           op_q;
  logic [5:0]     cnt;
  logic [WCW-1:0] wait_cnt;

  logic       wb_start;
  logic       wb_we;
  logic [1:0] wb_adr;
  logic [7:0] wb_wdata;
  logic       wb_done;
  logic [7:0] wb_rdata;

  i2cmb_wb_access u_wb (
    .clk   (clk_i),
    .rst   (rst_i),
    .start (wb_start),
    .we    (wb_we),
    .adr   (wb_adr),
    .wdata (wb_wdata),
    .done  (wb_done),
    .rdata (wb_rdata),
    .cyc_o (cyc_o),
    .stb_o (stb_o),
    .we_o  (we_o),
    .adr_o (adr_o),
    .dat_o (dat_o),
    .dat_i (dat_i),
    .ack_i (ack_i)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_RESET_INIT;
      phase       <= PH_ISSUE;
      kind        <= K_SETUP;
      step        <= '0;
      addr_q      <= '0;
      op_q        <= 1'b0;
      cnt         <= '0;
      wait_cnt    <= '0;
      wb_start    <= 1'b0;
      wb_we       <= 1'b0;
      wb_adr      <= '0;
      wb_wdata    <= '0;
      req_ready_o <= 1'b0;
      wr_ready_o  <= 1'b0;
      rd_valid_o  <= 1'b0;
      rd_data_o   <= '0;
      done_o      <= 1'b0;
      nak_o       <= 1'b0;
      err_o       <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      wb_start   <= 1'b0;
      rd_valid_o <= 1'b0;
      done_o     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            addr_q      <= req_addr_i;
            op_q        <= req_op_i;
            cnt         <= (req_len_i == 6'd0) ? 6'd1 : req_len_i;
            busy_o      <= 1'b1;
            nak_o       <= 1'b0;
            err_o       <= 1'b0;
            req_ready_o <= 1'b0;
            step        <= '0;
            phase       <= PH_ISSUE;
            state       <= ST_START;
          end
        end
        ST_FINISH: begin
          done_o      <= 1'b1;
          busy_o      <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          case (phase)
            PH_ISSUE: begin
              wb_start <= 1'b1;
              wb_we    <= 1'b1;
              wb_adr   <= REG_CMDR;
              kind     <= K_CMD;
              phase    <= PH_WB;
              case (state)
                ST_RESET_INIT: begin
                  if (step == 2'd0) begin
                    wb_adr   <= REG_CSR;
                    wb_wdata <= CSR_ENABLE;
                    kind     <= K_SETUP;
                  end else if (step == 2'd1) begin
                    wb_adr   <= REG_DPR;
                    wb_wdata <= 8'(BUS_ID);
                    kind     <= K_SETUP;
                  end else begin
                    wb_wdata <= cmdr_word(CMD_SET_BUS);
                  end
                end
                ST_START: wb_wdata <= cmdr_word(CMD_START);
                ST_ADDR: begin
                  if (step == 2'd0) begin
                    wb_adr   <= REG_DPR;
                    wb_wdata <= {addr_q, op_q};
                    kind     <= K_SETUP;
                  end else begin
                    wb_wdata <= cmdr_word(CMD_WRITE);
                  end
                end
                ST_WDATA: wb_wdata <= cmdr_word(CMD_WRITE);
                ST_RDATA: wb_wdata <= (cnt <= 6'd1) ? cmdr_word(CMD_READ_NAK)
                                                    : cmdr_word(CMD_READ_ACK);
                default:  wb_wdata <= cmdr_word(CMD_STOP);
              endcase
            end
            PH_WB: begin
              if (wb_done) begin
                case (kind)
                  K_SETUP: begin
                    step  <= step + 2'd1;
                    phase <= PH_ISSUE;
                  end
                  K_CMD: begin
                    wait_cnt <= '0;
                    phase    <= PH_IRQ;
                  end
                  K_RDDPR: begin
                    rd_valid_o <= 1'b1;
                    rd_data_o  <= wb_rdata;
                    phase      <= PH_ISSUE;
                    if (cnt > 6'd1) begin
                      cnt <= cnt - 6'd1;
                    end else begin
                      cnt   <= '0;
                      state <= ST_STOP;
                    end
                  end
                  default: begin
                    // Status byte from CMDR decides the next state.
                    step  <= '0;
                    phase <= PH_ISSUE;
                    if (wb_rdata[STAT_AL] || wb_rdata[STAT_ERR]) begin
                      err_o <= 1'b1;
                      state <= ST_FINISH;
                    end else begin
                      case (state)
                        ST_RESET_INIT: begin
                          req_ready_o <= 1'b1;
                          state       <= ST_IDLE;
                        end
                        ST_START: state <= ST_ADDR;
                        ST_ADDR: begin
                          if (wb_rdata[STAT_NAK]) begin
                            nak_o <= 1'b1;
                            state <= ST_STOP;
                          end else if (op_q) begin
                            state <= ST_RDATA;
                          end else begin
                            state      <= ST_WDATA;
                            phase      <= PH_BYTE;
                            wr_ready_o <= 1'b1;
                          end
                        end
                        ST_WDATA: begin
                          if (wb_rdata[STAT_NAK]) begin
                            nak_o <= 1'b1;
                            state <= ST_STOP;
                          end else if (cnt > 6'd1) begin
                            cnt        <= cnt - 6'd1;
                            phase      <= PH_BYTE;
                            wr_ready_o <= 1'b1;
                          end else begin
                            cnt   <= '0;
                            state <= ST_STOP;
                          end
                        end
                        ST_RDATA: begin
                          wb_start <= 1'b1;
                          wb_we    <= 1'b0;
                          wb_adr   <= REG_DPR;
                          wb_wdata <= '0;
                          kind     <= K_RDDPR;
                          phase    <= PH_WB;
                        end
                        default: state <= ST_FINISH;
                      endcase
                    end
                  end
                endcase
              end
            end
            PH_IRQ: begin
              if (irq_i) begin
                wb_start <= 1'b1;
                wb_we    <= 1'b0;
                wb_adr   <= REG_CMDR;
                wb_wdata <= '0;
                kind     <= K_STAT;
                phase    <= PH_WB;
              end else if (wait_cnt == WAIT_LAST) begin
                err_o       <= 1'b1;
                done_o      <= 1'b1;
                busy_o      <= 1'b0;
                req_ready_o <= 1'b1;
                phase       <= PH_ISSUE;
                state       <= ST_IDLE;
              end else begin
                wait_cnt <= wait_cnt + 1'b1;
              end
            end
            default: begin
              if (wr_valid_i && wr_ready_o) begin
                wr_ready_o <= 1'b0;
                wb_start   <= 1'b1;
                wb_we      <= 1'b1;
                wb_adr     <= REG_DPR;
                wb_wdata   <= wr_data_i;
                kind       <= K_SETUP;
                phase      <= PH_WB;
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule
